// File: rtl/text_overlay_param.sv
`default_nettype none
// ============================================================================
// Module      : text_overlay_param
// Description : Parametrised text overlay. Maps the current pixel
//               (Columna, Fila) to a character cell, reads a writable text
//               buffer and looks the glyph up in a character ROM. Produces a
//               1-bit pixel plus a 3-bit colour index with a fixed 3-cycle
//               latency. Adds a ready/valid write port, a buffer-clear state
//               machine, integer glyph scaling, per-cell blink and a cursor.
//               All logic runs on the falling edge of NCLK.
// Ports       : NCLK/RST                - pixel clock (falling edge), async
//                                         active-high reset
//               Columna/Fila/Activo     - pixel position and video-active
//               frame_start             - one pulse per frame (blink timebase)
//               wr_*                    - text buffer write port (ready/valid),
//                                         wr_err flags out-of-range writes
//               clr_req/busy            - full-buffer clear request / status
//               cursor_en/_col/_row     - blinking cursor control
//               Data/Color              - glyph pixel and its colour index
// Revision    : 1.0 - initial release
// ============================================================================
module text_overlay_param #(
    parameter int COLS         = 80,
    parameter int ROWS         = 60,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 32,
    parameter int H_BITS       = 11,
    parameter int V_BITS       = 10
) (
    input  logic              NCLK,
    input  logic              RST,
    input  logic [H_BITS-1:0] Columna,
    input  logic [V_BITS-1:0] Fila,
    input  logic              Activo,
    input  logic              frame_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [6:0]        wr_col,
    input  logic [5:0]        wr_row,
    input  logic [6:0]        wr_char,
    input  logic [3:0]        wr_attr,
    output logic              wr_err,
    input  logic              clr_req,
    input  logic              cursor_en,
    input  logic [6:0]        cursor_col,
    input  logic [5:0]        cursor_row,
    output logic              Data,
    output logic [2:0]        Color,
    output logic              busy
);

    localparam int c_DEPTH = COLS * ROWS;
    localparam int c_AW    = $clog2(c_DEPTH);
    localparam int c_SH    = 3 + SCALE_LOG2;
    localparam int c_BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_AW-1:0] c_LAST_ADDR  = c_AW'(c_DEPTH - 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_FRAMES - 1);
    // Cleared cell: white (colour 7), no blink, ASCII space
    localparam logic [10:0]     c_BLANK      = {4'b0111, 7'h20};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Character ROM: one 8-pixel row per (code, glyph row); bit 7 is the
    // leftmost pixel. Codes without a bitmap (including space) are blank.
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_glyph_row(input logic [6:0] ch,
                                               input logic [2:0] y);
        logic [7:0] row;
        row = 8'h00;
        case (ch)
            7'h41: begin // 'A'
                case (y)
                    3'd0:       row = 8'h18;
                    3'd1:       row = 8'h3C;
                    3'd4:       row = 8'h7E;
                    3'd7:       row = 8'h00;
                    default:    row = 8'h66;
                endcase
            end
            7'h42: begin // 'B'
                case (y)
                    3'd0, 3'd3, 3'd6: row = 8'h7C;
                    3'd7:             row = 8'h00;
                    default:          row = 8'h66;
                endcase
            end
            7'h48: begin // 'H'
                case (y)
                    3'd3:    row = 8'h7E;
                    3'd7:    row = 8'h00;
                    default: row = 8'h66;
                endcase
            end
            7'h7F:   row = 8'hFF; // solid block
            default: row = 8'h00;
        endcase
        return row;
    endfunction

    // ------------------------------------------------------------------
    // Pixel -> cell mapping (feeds stage 1)
    // ------------------------------------------------------------------
    logic [H_BITS-1:0] w_cell_col;
    logic [V_BITS-1:0] w_cell_row;
    logic [2:0]        w_gx;
    logic [2:0]        w_gy;
    logic              w_in_range;
    logic              w_cur_hit;
    logic [c_AW-1:0]   w_rd_addr;

    always_comb begin
        w_cell_col = Columna >> c_SH;
        w_cell_row = Fila >> c_SH;
        w_gx       = 3'(Columna >> SCALE_LOG2);
        w_gy       = 3'(Fila >> SCALE_LOG2);
        w_in_range = (32'(w_cell_col) < 32'(COLS)) && (32'(w_cell_row) < 32'(ROWS));
        // Out-of-range pixels read address 0 so the RAM is never indexed
        // beyond its depth; their output is forced to 0 anyway.
        w_rd_addr  = w_in_range ? c_AW'(32'(w_cell_row) * 32'(COLS) + 32'(w_cell_col))
                                : '0;
        w_cur_hit  = cursor_en
                  && (32'(w_cell_col) == 32'(cursor_col))
                  && (32'(w_cell_row) == 32'(cursor_row));
    end

    // ------------------------------------------------------------------
    // Write port / clear state machine
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_AW-1:0] r_clr_addr;
    logic            r_wr_err;
    logic            w_wr_oor;
    logic [c_AW-1:0] w_wr_addr;
    logic            w_we;
    logic [c_AW-1:0] w_waddr;
    logic [10:0]     w_wdata;

    assign w_wr_oor  = !((32'(wr_col) < 32'(COLS)) && (32'(wr_row) < 32'(ROWS)));
    assign w_wr_addr = w_wr_oor ? '0 : c_AW'(32'(wr_row) * 32'(COLS) + 32'(wr_col));

    always_comb begin
        w_state_nxt = r_state;
        wr_ready    = 1'b0;
        busy        = 1'b0;
        w_we        = 1'b0;
        w_waddr     = '0;
        w_wdata     = '0;
        case (r_state)
            ST_IDLE: begin
                wr_ready = 1'b1;
                // Out-of-range writes are accepted but dropped.
                if (wr_valid && !w_wr_oor) begin
                    w_we    = 1'b1;
                    w_waddr = w_wr_addr;
                    w_wdata = {wr_attr, wr_char};
                end
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = c_BLANK;
                if (r_clr_addr == c_LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(negedge NCLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_err <= wr_valid && wr_ready && w_wr_oor;
            // Address only advances while clearing; it is parked at 0
            // otherwise so the next clear always starts from the top.
            if ((r_state == ST_CLEAR) && (r_clr_addr != c_LAST_ADDR)) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end else begin
                r_clr_addr <= '0;
            end
        end
    end

    assign wr_err = r_wr_err;

    // ------------------------------------------------------------------
    // Blink timebase
    // ------------------------------------------------------------------
    logic [c_BW-1:0] r_blink_cnt;
    logic            r_phase;

    always_ff @(negedge NCLK or posedge RST) begin
        if (RST) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (frame_start) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Text buffer: one write port, one synchronous read port (stage 2).
    // Read returns the old contents on a same-cycle write (no bypass).
    // ------------------------------------------------------------------
    logic [10:0]     r_mem [c_DEPTH];
    logic [10:0]     r_s2_entry;
    logic [c_AW-1:0] r_s1_addr;

    always_ff @(negedge NCLK) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_s2_entry <= r_mem[r_s1_addr];
    end

    // ------------------------------------------------------------------
    // Display pipeline: S1 (map) -> S2 (buffer) -> S3 (ROM) -> output
    // ------------------------------------------------------------------
    logic [2:0] r_s1_gx, r_s1_gy, r_s2_gx, r_s2_gy;
    logic       r_s1_vis, r_s2_vis, r_s3_vis;
    logic       r_s1_cur, r_s2_cur, r_s3_cur;
    logic       r_s3_bit;
    logic [3:0] r_s3_attr;
    logic [7:0] w_rom_row;
    logic       w_pix;

    assign w_rom_row = f_glyph_row(r_s2_entry[6:0], r_s2_gy);

    always_ff @(negedge NCLK or posedge RST) begin
        if (RST) begin
            r_s1_addr <= '0;
            r_s1_gx   <= '0;
            r_s1_gy   <= '0;
            r_s1_vis  <= 1'b0;
            r_s1_cur  <= 1'b0;
            r_s2_gx   <= '0;
            r_s2_gy   <= '0;
            r_s2_vis  <= 1'b0;
            r_s2_cur  <= 1'b0;
            r_s3_bit  <= 1'b0;
            r_s3_attr <= '0;
            r_s3_vis  <= 1'b0;
            r_s3_cur  <= 1'b0;
        end else begin
            r_s1_addr <= w_rd_addr;
            r_s1_gx   <= w_gx;
            r_s1_gy   <= w_gy;
            r_s1_vis  <= Activo && w_in_range;
            r_s1_cur  <= w_cur_hit;
            r_s2_gx   <= r_s1_gx;
            r_s2_gy   <= r_s1_gy;
            r_s2_vis  <= r_s1_vis;
            r_s2_cur  <= r_s1_cur;
            r_s3_bit  <= w_rom_row[3'd7 - r_s2_gx];
            r_s3_attr <= r_s2_entry[10:7];
            r_s3_vis  <= r_s2_vis;
            r_s3_cur  <= r_s2_cur;
        end
    end

    // Blink blanks the glyph in phase 1; the cursor inverts it in phase 0,
    // so a cursor over a blinking cell still flashes in step with it.
    always_comb begin
        w_pix = r_s3_bit;
        if (r_s3_attr[3] && r_phase) begin
            w_pix = 1'b0;
        end
        if (r_s3_cur && !r_phase) begin
            w_pix = ~w_pix;
        end
    end

    always_ff @(negedge NCLK or posedge RST) begin
        if (RST) begin
            Data  <= 1'b0;
            Color <= 3'b000;
        end else if (r_s3_vis) begin
            Data  <= w_pix;
            Color <= w_pix ? r_s3_attr[2:0] : 3'b000;
        end else begin
            Data  <= 1'b0;
            Color <= 3'b000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_overlay_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_overlay_param
// Description : Directed self-checking bench for text_overlay_param. Two
//               instances share all inputs: one unscaled, one with 2x glyph
//               scaling; both with a 2-frame blink half-period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_overlay_param;

    logic        NCLK = 1'b0;
    logic        RST;
    logic [10:0] Columna;
    logic [9:0]  Fila;
    logic        Activo, frame_start, wr_valid, clr_req, cursor_en;
    logic [6:0]  wr_col, wr_char, cursor_col;
    logic [5:0]  wr_row, cursor_row;
    logic [3:0]  wr_attr;
    logic        a_wr_ready, a_wr_err, a_data, a_busy;
    logic        b_wr_ready, b_wr_err, b_data, b_busy;
    logic [2:0]  a_color, b_color;

    always #5 NCLK = ~NCLK;

    text_overlay_param #(.SCALE_LOG2(0), .BLINK_FRAMES(2)) u_dut_a (
        .NCLK(NCLK), .RST(RST), .Columna(Columna), .Fila(Fila), .Activo(Activo),
        .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
        .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char), .wr_attr(wr_attr),
        .wr_err(a_wr_err), .clr_req(clr_req), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .Data(a_data), .Color(a_color), .busy(a_busy)
    );

    text_overlay_param #(.SCALE_LOG2(1), .BLINK_FRAMES(2)) u_dut_b (
        .NCLK(NCLK), .RST(RST), .Columna(Columna), .Fila(Fila), .Activo(Activo),
        .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
        .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char), .wr_attr(wr_attr),
        .wr_err(b_wr_err), .clr_req(clr_req), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .Data(b_data), .Color(b_color), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model of the buffer and display ----------
    logic [6:0] m_char [4800];
    logic [3:0] m_attr [4800];
    bit         m_phase;
    int         m_fcnt;
    logic [7:0] glyph_a [8] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};

    function automatic void m_clear();
        for (int i = 0; i < 4800; i++) begin
            m_char[i] = 7'h20;
            m_attr[i] = 4'b0111;
        end
    endfunction

    function automatic logic [3:0] m_pix(input int x, input int y, input int s, input bit act);
        int cc, cr, idx, gx, gy;
        logic [7:0] row;
        logic p;
        cc = x >> (3 + s);
        cr = y >> (3 + s);
        if (!act || cc >= 80 || cr >= 60) return 4'h0;
        idx = cr * 80 + cc;
        gx  = (x >> s) & 7;
        gy  = (y >> s) & 7;
        row = (m_char[idx] == 7'h41) ? glyph_a[gy] : 8'h00;
        p   = row[7 - gx];
        if (m_attr[idx][3] && m_phase) p = 1'b0;
        if (cursor_en && cc == int'(cursor_col) && cr == int'(cursor_row) && !m_phase) p = ~p;
        return {p, p ? m_attr[idx][2:0] : 3'b000};
    endfunction

    typedef struct packed {
        logic [3:0] ea;
        logic [3:0] eb;
    } pix_t;
    pix_t q[$];

    // Drive one pixel per clock; the result is due 4 posedges later
    // (3 falling edges after the one that samples it).
    task automatic step(input int x, input int y, input bit act);
        pix_t e;
        @(posedge NCLK);
        if (q.size() >= 4) begin
            e = q.pop_front();
            chk("pix_a", {28'h0, a_data, a_color}, {28'h0, e.ea});
            chk("pix_b", {28'h0, b_data, b_color}, {28'h0, e.eb});
        end
        Columna = 11'(x);
        Fila    = 10'(y);
        Activo  = act;
        e.ea = m_pix(x, y, 0, act);
        e.eb = m_pix(x, y, 1, act);
        q.push_back(e);
    endtask

    task automatic flush();
        repeat (4) step(0, 0, 1'b0);
    endtask

    task automatic sweep(input int x0, input int y0, input int w, input int h);
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                step(x, y, 1'b1);
        flush();
    endtask

    task automatic wr(input int col, input int row, input logic [6:0] ch,
                      input logic [3:0] at, input bit exp_err);
        @(posedge NCLK);
        chk("wr_ready", a_wr_ready, 1);
        wr_valid = 1'b1;
        wr_col   = 7'(col);
        wr_row   = 6'(row);
        wr_char  = ch;
        wr_attr  = at;
        @(posedge NCLK);
        wr_valid = 1'b0;
        chk("wr_err_pulse", a_wr_err, exp_err);
        @(posedge NCLK);
        chk("wr_err_clear", a_wr_err, 0);
        if (!exp_err) begin
            m_char[row * 80 + col] = ch;
            m_attr[row * 80 + col] = at;
        end
    endtask

    task automatic pulse();
        @(posedge NCLK);
        frame_start = 1'b1;
        @(posedge NCLK);
        frame_start = 1'b0;
        m_fcnt++;
        if (m_fcnt == 2) begin
            m_fcnt  = 0;
            m_phase = ~m_phase;
        end
    endtask

    // Counts sampled busy cycles starting at the current posedge;
    // optionally re-requests a clear partway through.
    task automatic count_busy(input string tag, input int poke);
        int n;
        n = 0;
        while (a_busy && n < 10000) begin
            if (n == 5) chk({tag, "_ready_low"}, a_wr_ready, 0);
            clr_req = (n == poke);
            n++;
            @(posedge NCLK);
        end
        clr_req = 1'b0;
        chk(tag, n, 4800);
        chk({tag, "_b"}, b_busy, 0);
        chk({tag, "_ready"}, a_wr_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; Columna = '0; Fila = '0; Activo = 1'b0; frame_start = 1'b0;
        wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0; wr_attr = '0;
        clr_req = 1'b0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
        m_clear(); m_phase = 0; m_fcnt = 0;

        // Reset state
        repeat (3) @(posedge NCLK);
        chk("rst_data", a_data, 0);
        chk("rst_color", a_color, 0);
        chk("rst_wr_err", a_wr_err, 0);
        chk("rst_busy", a_busy, 1);
        chk("rst_wr_ready", a_wr_ready, 0);
        RST = 1'b0;
        count_busy("boot_busy", -1);

        // Every cell blank after the boot clear
        for (int cr = 0; cr < 60; cr++)
            for (int cc = 0; cc < 80; cc++)
                step(cc * 8 + 3, cr * 8 + 4, 1'b1);
        flush();

        // 'A' in colour 2 at (0,0); then (1,0) exposes the scaled cell edge
        wr(0, 0, 7'h41, 4'b0010, 1'b0);
        sweep(0, 0, 8, 8);
        wr(1, 0, 7'h41, 4'b0011, 1'b0);
        sweep(0, 0, 32, 16);

        // Activo low masks everything
        for (int x = 0; x < 8; x++) step(x, 2, 1'b0);
        flush();

        // Blink cell (2,0): visible, visible, blank, blank, visible
        wr(2, 0, 7'h41, 4'b1100, 1'b0);
        sweep(16, 0, 8, 8);
        for (int k = 0; k < 4; k++) begin
            pulse();
            sweep(16, 0, 8, 8);
        end

        // Cursor over a space, then over 'A'
        cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 6'd5;
        sweep(40, 40, 8, 8);
        pulse(); pulse();
        sweep(40, 40, 8, 8);
        pulse(); pulse();
        cursor_col = 7'd0; cursor_row = 6'd0;
        sweep(0, 0, 8, 8);
        cursor_en = 1'b0;

        // Out-of-range writes are flagged and dropped
        wr(80, 0, 7'h41, 4'b0101, 1'b1);
        wr(0, 60, 7'h41, 4'b0101, 1'b1);
        sweep(0, 8, 8, 8);

        // Out-of-range pixels stay dark even where the address would alias
        wr(0, 1, 7'h41, 4'b0001, 1'b0);
        sweep(640, 0, 8, 8);
        sweep(0, 8, 8, 8);

        // Clear with a simultaneous write; a repeat request is ignored
        @(posedge NCLK);
        chk("clr_wr_ready", a_wr_ready, 1);
        clr_req = 1'b1; wr_valid = 1'b1; wr_col = 7'd3; wr_row = 6'd3;
        wr_char = 7'h41; wr_attr = 4'b0010;
        @(posedge NCLK);
        clr_req = 1'b0; wr_valid = 1'b0;
        count_busy("clr_busy", 100);
        m_clear();
        sweep(24, 24, 8, 8);
        sweep(0, 0, 8, 8);

        // Reset at clear address 1000 restarts the clear from 0
        wr(79, 59, 7'h41, 4'b0010, 1'b0);
        pulse();
        @(posedge NCLK);
        clr_req = 1'b1;
        @(posedge NCLK);
        clr_req = 1'b0;
        repeat (1000) @(posedge NCLK);
        RST = 1'b1;
        #1;
        chk("rst2_busy", a_busy, 1);
        chk("rst2_ready", a_wr_ready, 0);
        chk("rst2_data", a_data, 0);
        m_phase = 0; m_fcnt = 0;
        @(posedge NCLK);
        RST = 1'b0;
        count_busy("rst_clr_busy", -1);
        m_clear();
        sweep(632, 472, 8, 8);

        // Blink counter restarted by reset: one pulse keeps phase 0
        wr(0, 0, 7'h41, 4'b1001, 1'b0);
        pulse();
        sweep(0, 0, 8, 8);
        pulse();
        sweep(0, 0, 8, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
